// File: rtl/spectrum_frame_scheduler_if.sv
// spectrum_frame_scheduler_if
//   Bundles the scheduler's frame, search-engine, display and status signals.
//   The scheduler connects through the master modport. The surrounding system
//   (FFT buffer, max-search engine, VGA renderer) connects through the slave modport.
//
//   frame_valid_i  : new spectrum frame written (pulse)
//   vsync_i        : VGA frame boundary (pulse)
//   search_start_o : start pulse to the max-search engine
//   search_done_i  : search finished; search_max_i is valid in the same cycle
//   search_max_i   : maximum magnitude found by the search
//   search_addr_i  : buffer read address from the search engine
//   disp_addr_i    : buffer read address from the VGA renderer
//   buf_addr_o     : muxed buffer read address
//   disp_grant_o   : display owns the buffer and has valid scaling
//   max_value_o    : published frame maximum
//   scale_shift_o  : published bar-height right shift
//   max_valid_o    : at least one result has been published
//   dropped_cnt_o  : saturating count of discarded frames
//   timeout_o      : sticky search watchdog flag
interface spectrum_frame_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              frame_valid_i;
  logic              vsync_i;
  logic              search_start_o;
  logic              search_done_i;
  logic [DATA_W-1:0] search_max_i;
  logic [ADDR_W-1:0] search_addr_i;
  logic [ADDR_W-1:0] disp_addr_i;
  logic [ADDR_W-1:0] buf_addr_o;
  logic              disp_grant_o;
  logic [DATA_W-1:0] max_value_o;
  logic [5:0]        scale_shift_o;
  logic              max_valid_o;
  logic [7:0]        dropped_cnt_o;
  logic              timeout_o;

  modport master (
    input  frame_valid_i, vsync_i, search_done_i, search_max_i,
           search_addr_i, disp_addr_i,
    output search_start_o, buf_addr_o, disp_grant_o, max_value_o,
           scale_shift_o, max_valid_o, dropped_cnt_o, timeout_o
  );

  modport slave (
    output frame_valid_i, vsync_i, search_done_i, search_max_i,
           search_addr_i, disp_addr_i,
    input  search_start_o, buf_addr_o, disp_grant_o, max_value_o,
           scale_shift_o, max_valid_o, dropped_cnt_o, timeout_o
  );
endinterface

// File: rtl/spectrum_frame_scheduler.sv
// spectrum_frame_scheduler
//   Per-frame sequencer. Each new spectrum frame triggers a max search. The
//   result is turned into a normalisation shift. Both values are published
//   together on a VGA vsync, so a displayed frame never mixes two scalings.
//   The scheduler also arbitrates the spectrum buffer read address between
//   the search engine and the display.
//
//   Optional feature macro: SCHED_TIMEOUT_EN. When defined, a search that
//   runs TIMEOUT_CYCLES cycles without a done pulse is abandoned. timeout_o
//   is then set and stays set until reset.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : spectrum_frame_scheduler_if.master (see the interface file for the
//         signal list)
module spectrum_frame_scheduler #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 64,
  parameter int DISP_BITS      = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  spectrum_frame_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, START, SEARCH, NORM, WAIT_VSYNC, SHOW
  } state_t;

  // Wide enough to hold the count of significant bits, 0..DATA_W.
  localparam int SIG_W = $clog2(DATA_W + 1);

  state_t            state_reg, state_next;
  logic              pending_reg, pending_next;
  logic [DATA_W-1:0] max_lat_reg, max_lat_next;
  logic [5:0]        shift_lat_reg, shift_lat_next;
  logic [DATA_W-1:0] max_value_reg, max_value_next;
  logic [5:0]        scale_shift_reg, scale_shift_next;
  logic              max_valid_reg, max_valid_next;
  logic [7:0]        dropped_cnt_reg, dropped_cnt_next;
  logic              start_now;
  logic              drop_frame;

  logic [SIG_W-1:0]  sig_bits;
  logic [5:0]        norm_shift;
  logic [ADDR_W-1:0] buf_addr;

`ifdef SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]   timeout_cnt_reg, timeout_cnt_next;
  logic              timeout_reg, timeout_next;
`endif

  // Number of significant bits in the latched maximum. This is p+1, where p
  // is the index of the highest set bit, or 0 for a zero maximum. The shift
  // is the amount by which this exceeds the bar resolution, so a zero
  // maximum and small maxima both give a shift of 0.
  always_comb begin
    sig_bits = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (max_lat_reg[i]) sig_bits = SIG_W'(i + 1);
    end
  end

  assign norm_shift = (int'(sig_bits) > DISP_BITS) ?
                      6'(int'(sig_bits) - DISP_BITS) : 6'd0;

  always_comb begin
    state_next       = state_reg;
    pending_next     = pending_reg;
    max_lat_next     = max_lat_reg;
    shift_lat_next   = shift_lat_reg;
    max_value_next   = max_value_reg;
    scale_shift_next = scale_shift_reg;
    max_valid_next   = max_valid_reg;
    dropped_cnt_next = dropped_cnt_reg;
    start_now        = 1'b0;
    drop_frame       = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    timeout_next     = timeout_reg;
    timeout_cnt_next = (state_reg == SEARCH) ? timeout_cnt_reg + TO_W'(1) : '0;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.frame_valid_i || pending_reg) begin
          state_next = START;
          start_now  = 1'b1;
        end
      end
      START: state_next = SEARCH;
      SEARCH: begin
        if (bus.search_done_i) begin
          max_lat_next = bus.search_max_i;
          state_next   = NORM;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
`endif
      end
      NORM: begin
        shift_lat_next = norm_shift;
        state_next     = WAIT_VSYNC;
      end
      WAIT_VSYNC: begin
        if (bus.vsync_i) begin
          max_value_next   = max_lat_reg;
          scale_shift_next = shift_lat_reg;
          max_valid_next   = 1'b1;
          state_next       = SHOW;
        end
      end
      SHOW: begin
        if (bus.vsync_i && (pending_reg || bus.frame_valid_i)) begin
          state_next = START;
          start_now  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Single-entry frame queue. A start consumes the queued frame. A second
    // frame that cannot be queued is counted as dropped.
    if (start_now) begin
      pending_next = 1'b0;
      drop_frame   = bus.frame_valid_i && pending_reg;
    end else if (bus.frame_valid_i) begin
      if (pending_reg) drop_frame   = 1'b1;
      else             pending_next = 1'b1;
    end

    if (drop_frame && (dropped_cnt_reg != 8'hFF)) begin
      dropped_cnt_next = dropped_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      pending_reg     <= 1'b0;
      max_lat_reg     <= '0;
      shift_lat_reg   <= '0;
      max_value_reg   <= '0;
      scale_shift_reg <= '0;
      max_valid_reg   <= 1'b0;
      dropped_cnt_reg <= '0;
`ifdef SCHED_TIMEOUT_EN
      timeout_cnt_reg <= '0;
      timeout_reg     <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      max_lat_reg     <= max_lat_next;
      shift_lat_reg   <= shift_lat_next;
      max_value_reg   <= max_value_next;
      scale_shift_reg <= scale_shift_next;
      max_valid_reg   <= max_valid_next;
      dropped_cnt_reg <= dropped_cnt_next;
`ifdef SCHED_TIMEOUT_EN
      timeout_cnt_reg <= timeout_cnt_next;
      timeout_reg     <= timeout_next;
`endif
    end
  end

  // The search engine owns the buffer only while a search is being launched
  // or is running. Otherwise the display reads. Its data is meaningful only
  // once a scaling has been published.
  always_comb begin
    buf_addr = bus.disp_addr_i;
    if ((state_reg == START) || (state_reg == SEARCH)) begin
      buf_addr = bus.search_addr_i;
    end
  end

  assign bus.buf_addr_o     = buf_addr;
  assign bus.disp_grant_o   = (state_reg != START) && (state_reg != SEARCH) && max_valid_reg;
  assign bus.search_start_o = (state_reg == START);
  assign bus.max_value_o    = max_value_reg;
  assign bus.scale_shift_o  = scale_shift_reg;
  assign bus.max_valid_o    = max_valid_reg;
  assign bus.dropped_cnt_o  = dropped_cnt_reg;
`ifdef SCHED_TIMEOUT_EN
  assign bus.timeout_o      = timeout_reg;
`else
  assign bus.timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spectrum_frame_scheduler.sv
module tb_spectrum_frame_scheduler;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_frame_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spectrum_frame_scheduler #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DISP_BITS(9), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] max_in;
    logic [5:0]  exp_shift;
  } vec_t;

  vec_t vecs [8];

  localparam logic [ADDR_W-1:0] DISP_A = 10'h155;
  localparam logic [ADDR_W-1:0] SRCH_A = 10'h2AA;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] prev_max;

  initial begin
    vecs[0] = '{64'h0000_0000_0001_2345, 6'd8};
    vecs[1] = '{64'h0,                   6'd0};
    vecs[2] = '{64'h8000_0000_0000_0000, 6'd55};
    vecs[3] = '{64'h0000_0000_0000_01FF, 6'd0};
    vecs[4] = '{64'h0000_0000_0000_0200, 6'd1};
    vecs[5] = '{64'h0000_0000_FFFF_FFFF, 6'd23};
    vecs[6] = '{64'h0000_0000_0000_0001, 6'd0};
    vecs[7] = '{64'h0000_0000_0001_0000, 6'd8};

    rst = 1'b1;
    bus.frame_valid_i = 1'b0;
    bus.vsync_i       = 1'b0;
    bus.search_done_i = 1'b0;
    bus.search_max_i  = '0;
    bus.search_addr_i = SRCH_A;
    bus.disp_addr_i   = DISP_A;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_start",   64'(bus.search_start_o), 64'd0);
    chk("rst_grant",   64'(bus.disp_grant_o),   64'd0);
    chk("rst_max",     bus.max_value_o,         64'd0);
    chk("rst_shift",   64'(bus.scale_shift_o),  64'd0);
    chk("rst_valid",   64'(bus.max_valid_o),    64'd0);
    chk("rst_dropped", 64'(bus.dropped_cnt_o),  64'd0);
    chk("rst_timeout", 64'(bus.timeout_o),      64'd0);
    chk("rst_addr",    64'(bus.buf_addr_o),     64'(DISP_A));
    rst = 1'b0;
    repeat (7) tick();
    chk("idle_start", 64'(bus.search_start_o), 64'd0);

    // ---- table-driven frames ----
    prev_max = 64'd0;
    for (int k = 0; k < 8; k++) begin
      // Frame together with vsync starts from IDLE or from SHOW.
      bus.frame_valid_i = 1'b1;
      bus.vsync_i       = 1'b1;
      tick();
      bus.frame_valid_i = 1'b0;
      bus.vsync_i       = 1'b0;
      #1;
      chk($sformatf("v%0d_start_hi", k), 64'(bus.search_start_o), 64'd1);
      chk($sformatf("v%0d_grant_lo", k), 64'(bus.disp_grant_o),   64'd0);
      chk($sformatf("v%0d_addr_srch", k), 64'(bus.buf_addr_o),    64'(SRCH_A));
      tick();
      chk($sformatf("v%0d_start_lo", k), 64'(bus.search_start_o), 64'd0);
      bus.search_addr_i = 10'h0F0 + 10'(k);
      #1;
      chk($sformatf("v%0d_addr_follow", k), 64'(bus.buf_addr_o), 64'(10'h0F0 + 10'(k)));
      bus.search_addr_i = SRCH_A;
      bus.search_done_i = 1'b1;
      bus.search_max_i  = vecs[k].max_in;
      tick();
      bus.search_done_i = 1'b0;
      bus.search_max_i  = '0;
      tick();
      chk($sformatf("v%0d_hold_max", k), bus.max_value_o, prev_max);
      bus.vsync_i = 1'b1;
      tick();
      bus.vsync_i = 1'b0;
      #1;
      chk($sformatf("v%0d_max", k),   bus.max_value_o, vecs[k].max_in);
      chk($sformatf("v%0d_shift", k), 64'(bus.scale_shift_o), 64'(vecs[k].exp_shift));
      chk($sformatf("v%0d_valid", k), 64'(bus.max_valid_o),   64'd1);
      chk($sformatf("v%0d_grant", k), 64'(bus.disp_grant_o),  64'd1);
      chk($sformatf("v%0d_addr_disp", k), 64'(bus.buf_addr_o), 64'(DISP_A));
      prev_max = vecs[k].max_in;
    end

    // ---- done outside SEARCH is ignored ----
    bus.search_done_i = 1'b1;
    bus.search_max_i  = 64'hDEAD_BEEF;
    tick();
    bus.search_done_i = 1'b0;
    bus.vsync_i       = 1'b1;
    tick();
    bus.vsync_i = 1'b0;
    tick();
    chk("stale_done_max",   bus.max_value_o, 64'h0000_0000_0001_0000);
    chk("stale_done_start", 64'(bus.search_start_o), 64'd0);

    // ---- three frames in SHOW: one pending, two dropped ----
    bus.frame_valid_i = 1'b1;
    repeat (3) tick();
    bus.frame_valid_i = 1'b0;
    #1;
    chk("drop_cnt_2",   64'(bus.dropped_cnt_o), 64'd2);
    chk("drop_nostart", 64'(bus.search_start_o), 64'd0);
    bus.vsync_i = 1'b1;
    tick();
    bus.vsync_i = 1'b0;
    #1;
    chk("pending_start", 64'(bus.search_start_o), 64'd1);
    tick();

    // ---- done in same cycle as vsync: publish waits for the next vsync ----
    bus.search_done_i = 1'b1;
    bus.vsync_i       = 1'b1;
    bus.search_max_i  = 64'h400;
    tick();
    bus.search_done_i = 1'b0;
    bus.search_max_i  = '0;
    tick();                      // vsync still high during NORM
    bus.vsync_i = 1'b0;
    #1;
    chk("samecyc_nopub",  bus.max_value_o, 64'h0000_0000_0001_0000);
    tick();
    chk("samecyc_hold",   bus.max_value_o, 64'h0000_0000_0001_0000);
    bus.vsync_i = 1'b1;
    tick();
    bus.vsync_i = 1'b0;
    #1;
    chk("samecyc_pub_max",   bus.max_value_o, 64'h400);
    chk("samecyc_pub_shift", 64'(bus.scale_shift_o), 64'd2);

    // ---- watchdog ----
    bus.frame_valid_i = 1'b1;
    bus.vsync_i       = 1'b1;
    tick();
    bus.frame_valid_i = 1'b0;
    bus.vsync_i       = 1'b0;
    tick();                      // first SEARCH cycle
    repeat (1023) tick();
    chk("wd_still_search", 64'(bus.disp_grant_o), 64'd0);
    chk("wd_no_timeout",   64'(bus.timeout_o),    64'd0);
    tick();
`ifdef SCHED_TIMEOUT_EN
    chk("wd_timeout",  64'(bus.timeout_o),    64'd1);
    chk("wd_idle",     64'(bus.disp_grant_o), 64'd1);
    chk("wd_max_kept", bus.max_value_o,       64'h400);
    repeat (5) tick();
    chk("wd_sticky",   64'(bus.timeout_o),    64'd1);
    chk("wd_no_restart", 64'(bus.search_start_o), 64'd0);
`else
    chk("wd_disabled", 64'(bus.timeout_o),    64'd0);
    repeat (100) tick();
    chk("wd_stay_search", 64'(bus.disp_grant_o), 64'd0);
    chk("wd_stay_addr",   64'(bus.buf_addr_o),   64'(SRCH_A));
    chk("wd_max_kept",    bus.max_value_o,       64'h400);
`endif

    // ---- dropped counter saturation (from a fresh reset) ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.frame_valid_i = 1'b1;
    repeat (12) tick();          // start, pending, then 10 drops
    chk("sat_cnt_10", 64'(bus.dropped_cnt_o), 64'd10);
    repeat (290) tick();
    bus.frame_valid_i = 1'b0;
    #1;
    chk("sat_cnt_255", 64'(bus.dropped_cnt_o), 64'd255);

    // ---- reset mid-search: no start reissued ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_dropped", 64'(bus.dropped_cnt_o), 64'd0);
    chk("midrst_valid",   64'(bus.max_valid_o),   64'd0);
    chk("midrst_max",     bus.max_value_o,        64'd0);
    chk("midrst_addr",    64'(bus.buf_addr_o),    64'(DISP_A));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("midrst_nostart_%0d", c), 64'(bus.search_start_o), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spectrum_frame_scheduler.md
# spectrum_frame_scheduler

Sequences per-frame spectrum processing between the FFT output buffer, the max-search engine and VGA scan-out. For each new spectrum frame it starts a max search, waits for the result, and derives a display normalisation shift from it. It also arbitrates the single read address of the spectrum buffer between the search engine and the display reader. Results are published atomically at a VGA vertical sync, so a displayed frame never mixes old and new scaling.

## Interface
- `ADDR_W`, 10: spectrum buffer address width.
- `DATA_W`, 64: magnitude width.
- `DISP_BITS`, 9: vertical pixel resolution of a bar, in bits.
- `TIMEOUT_CYCLES`, 1024: search watchdog limit. Used only with `SCHED_TIMEOUT_EN`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `frame_valid_i` in 1: one-cycle pulse; a new frame has been written to the buffer.
- `vsync_i` in 1: one-cycle pulse marking the VGA frame boundary.
- `search_start_o` out 1: one-cycle start pulse to the max-search engine.
- `search_done_i` in 1: one-cycle pulse; `search_max_i` is valid in the same cycle.
- `search_max_i` in DATA_W: maximum magnitude found.
- `search_addr_i` in ADDR_W: read address from the search engine.
- `disp_addr_i` in ADDR_W: read address from the VGA renderer.
- `buf_addr_o` out ADDR_W: muxed read address to the buffer (combinational).
- `disp_grant_o` out 1: the display owns the buffer and its data is meaningful.
- `max_value_o` out DATA_W: published frame maximum.
- `scale_shift_o` out 6: published right-shift for bar height.
- `max_valid_o` out 1: at least one result has been published.
- `dropped_cnt_o` out 8: saturating count of frames discarded.
- `timeout_o` out 1: sticky flag, set when a search hits the watchdog limit.

## Operation
- States: IDLE, START, SEARCH, NORM, WAIT_VSYNC, SHOW.
- Internal registers: single-entry `pending` flag; `max_lat`/`shift_lat` staging registers.
- **IDLE**
  - If `frame_valid_i` or `pending`: go to START and clear `pending`.
- **START** (one cycle)
  - `search_start_o`=1, then go to SEARCH.
- **SEARCH**
  - On `search_done_i`: latch `search_max_i` into `max_lat`, then go to NORM.
- **NORM** (one cycle)
  - Let `p` be the index of the highest set bit of `max_lat`.
  - `shift_lat` = max(0, p+1−DISP_BITS). If `max_lat`=0, `shift_lat`=0.
  - Then go to WAIT_VSYNC.
- **WAIT_VSYNC**
  - On `vsync_i`: copy `max_lat` to `max_value_o` and `shift_lat` to `scale_shift_o`, set `max_valid_o`=1, go to SHOW.
- **SHOW**
  - On `vsync_i` with (`pending` or `frame_valid_i`): go to START and clear `pending`.
- **Frame arrival outside IDLE**
  - A `frame_valid_i` that does not cause a transition to START sets `pending` if it is clear.
  - If `pending` is already set, the frame increments `dropped_cnt_o`, which saturates at 255.
- **Address mux**
  - In START and SEARCH: `buf_addr_o`=`search_addr_i`, `disp_grant_o`=0.
  - In all other states: `buf_addr_o`=`disp_addr_i`, `disp_grant_o`=`max_valid_o`.

## Timing
- Reset:
  - State goes to IDLE.
  - `pending`, all counters and all registered outputs go to 0: `search_start_o`, `disp_grant_o`, `max_value_o`, `scale_shift_o`, `max_valid_o`, `dropped_cnt_o` and `timeout_o`.
  - `buf_addr_o`=`disp_addr_i`.
  - A reset mid-search abandons the search. No start pulse is reissued.
- `search_start_o` is decoded from state. It is high exactly in the cycle after the triggering `frame_valid_i`/`vsync_i`.
- `search_done_i` at cycle m: NORM at m+1, WAIT_VSYNC at m+2.
  - A `vsync_i` at m or m+1 is ignored.
  - A `vsync_i` at v≥m+2 publishes the outputs, visible at v+1.
- `search_done_i` outside SEARCH is ignored.
- Published outputs change only on the WAIT_VSYNC→SHOW edge. They are never torn.
- `frame_valid_i` in IDLE together with `pending` set: START is entered, `pending` is cleared, and one frame is counted as dropped.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in SEARCH.
  - After TIMEOUT_CYCLES cycles without `search_done_i`: set `timeout_o` (sticky until reset), leave published outputs unchanged, and go to IDLE.
- Undefined: no counter is built, `timeout_o` is tied to 0, and SEARCH waits indefinitely.

## Test plan
- Reset, then `frame_valid_i` at cycle 10: `search_start_o` is high at cycle 11 only. `buf_addr_o` follows `search_addr_i` from cycle 11 until `search_done_i`.
- `search_max_i`=0x0000_0000_0001_2345 with done, then `vsync_i`: `max_value_o`=0x12345, `scale_shift_o`=8, `max_valid_o`=1 and `disp_grant_o`=1 one cycle after the vsync.
- `search_max_i`=0 gives shift 0. `search_max_i`=0x8000_0000_0000_0000 gives shift 55. `search_max_i`=0x1FF gives shift 0.
- In SHOW, three `frame_valid_i` pulses before the next `vsync_i`: `pending` is set and `dropped_cnt_o`=2. At vsync the FSM goes to START. After 300 further dropped frames `dropped_cnt_o`=255.
- Done asserted in the same cycle as `vsync_i`: no publish on that vsync. Publish happens on the next vsync.
- With `SCHED_TIMEOUT_EN` and no `search_done_i`: after 1024 SEARCH cycles `timeout_o`=1, the FSM is in IDLE, and `max_value_o` is unchanged. Without the macro the FSM stays in SEARCH.
